// File: rtl/n_bit_down_timer_if.sv
// Control and status bundle for n_bit_down_timer.
// Master drives load/enable controls and observes the count; slave is the timer.
// Controls are sampled every cycle; there is no backpressure.
interface n_bit_down_timer_if #(
    parameter int N = 4
);
    logic         load;
    logic [N-1:0] load_val;
    logic         en;
    logic         auto_reload;
    logic [N-1:0] out;
    logic         zero;
    logic         tc_pulse;
    logic         busy;

    modport master (
        output load, load_val, en, auto_reload,
        input  out, zero, tc_pulse, busy
    );

    modport slave (
        input  load, load_val, en, auto_reload,
        output out, zero, tc_pulse, busy
    );
endinterface

// File: rtl/n_bit_down_timer.sv
// Loadable N-bit down-counter with terminal-count pulse and optional auto-reload.
// Latency: load to out 1 cycle; tc_pulse appears in the same cycle out shows 0/reload.
// No backpressure: en gates counting, load always wins over terminal count and decrement.
module n_bit_down_timer #(
    parameter int N = 4
) (
    input  logic               clk,
    input  logic               rstn,
    n_bit_down_timer_if.slave  tmr
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [1:0]   state_q, state_d;
    logic [N-1:0] out_q, out_d;
    logic [N-1:0] reload_q, reload_d;
    logic         tc_q, tc_d;
    logic         busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (tmr.load) begin
            out_d    = tmr.load_val;
            reload_d = tmr.load_val;
            if (tmr.load_val == '0) begin
                state_d = ST_IDLE;
            end else if (tmr.en) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_HOLD;
            end
        end else if ((state_q != ST_IDLE) && tmr.en) begin
            // out is never 0 outside IDLE; the 0 branch only guards against an impossible state.
            if (out_q == ONE) begin
                tc_d = 1'b1;
                if (tmr.auto_reload) begin
                    out_d   = reload_q;
                    state_d = ST_RUN;
                end else begin
                    out_d   = '0;
                    state_d = ST_IDLE;
                end
            end else if (out_q == '0) begin
                state_d = ST_IDLE;
            end else begin
                out_d   = out_q - ONE;
                state_d = ST_RUN;
            end
        end else if ((state_q == ST_RUN) && !tmr.en) begin
            state_d = ST_HOLD;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            out_q    <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
        end
    end

    assign tmr.out      = out_q;
    assign tmr.zero     = (out_q == '0);
    assign tmr.tc_pulse = tc_q;
    assign tmr.busy     = busy_q;

endmodule

// File: doc/n_bit_down_timer.md
Name: n_bit_down_timer

Overview:
- Synchronous, loadable N-bit down-counter with terminal-count detection and optional auto-reload.
- It counts in the opposite direction to the team's ripple up-counter.
- It consumes a programmed count and signals when that count expires.
- It is the timeout/interval generator that sits beside the free-running counters. Downstream logic consumes its single-cycle tc_pulse.

Parameters:
- N, 4, counter width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rstn  input  1  asynchronous, active-low reset.
- load  input  1  when high at an edge, load_val is captured.
- load_val  input  N  value captured into out and into the reload register.
- en  input  1  count enable; a decrement occurs on each edge where en=1 and state is RUN or HOLD.
- auto_reload  input  1  when 1, terminal count reloads from the reload register instead of stopping.
- out  output  N  current count (registered).
- zero  output  1  combinational, out == 0.
- tc_pulse  output  1  registered; high for exactly the one cycle after terminal count.
- busy  output  1  registered; high while state is not IDLE.

Behaviour:
- Reset (rstn=0, asynchronous, takes effect immediately, independent of clk):
  - out=0, reload register=0, state=IDLE, tc_pulse=0, busy=0, zero=1.
  - Reset asserted mid-count aborts the count immediately; no tc_pulse is produced.
- State machine (registered): IDLE, RUN, HOLD.
- Transitions:
  - Priority order: load > terminal count > decrement.
  - Any state, load=1: out<=load_val and reload<=load_val.
    - Next state is IDLE if load_val==0.
    - Otherwise next state is RUN if en=1, else HOLD.
    - No decrement happens on the load edge. tc_pulse<=0.
  - IDLE, load=0: out holds; en is ignored; no underflow or wrap. out=0 stays 0.
  - HOLD, load=0, en=0: out frozen.
  - HOLD, load=0, en=1: behaves exactly as RUN on that edge (decrement or terminal), then state=RUN.
  - RUN, load=0, en=0: out frozen; state=HOLD.
  - RUN, load=0, en=1, out>1: out<=out-1; tc_pulse<=0.
  - RUN, load=0, en=1, out==1 (terminal count): tc_pulse<=1.
    - If auto_reload=1: out<=reload; stay RUN.
    - If auto_reload=0: out<=0; state<=IDLE.
- tc_pulse is high only in the cycle immediately following a terminal-count edge. It is cleared on every other edge.
- Back-to-back terminal counts, with reload==1 and auto_reload=1, hold tc_pulse high on consecutive cycles. This is legal.
- Period with auto_reload: reload value R gives one tc_pulse every R enabled cycles.
- Simultaneous load and terminal count on the same edge: the load wins; tc_pulse<=0.
- auto_reload is sampled only at the terminal-count edge. Changing it mid-count has no other effect.
- Arithmetic: unsigned N-bit. out never underflows: the decrement from 1 is replaced by the terminal action, and 0 is never decremented.
- busy is high in RUN and HOLD, and low in IDLE.
- Latency:
  - load to out: 1 cycle.
  - Final enabled edge to tc_pulse: visible in the same cycle that out shows 0 (or the reload value).

Test Plan:
- Reset: with N=4 and out mid-count at 9, assert rstn=0 between clock edges -> out=0, busy=0, tc_pulse=0, zero=1 immediately, without waiting for a clock edge.
- One-shot: load_val=5, load=1 for one cycle, en=1, auto_reload=0.
  - Required: out goes 5,4,3,2,1,0.
  - tc_pulse is high for exactly one cycle, coincident with out=0.
  - busy falls with it; out remains 0 for 10 further enabled cycles.
- Pause: load 6, en=1 for 2 cycles (out=4), en=0 for 3 cycles, then en=1.
  - Required: out holds 4 and state is HOLD while paused; busy stays 1.
  - Count then resumes 3,2,1,0 and tc_pulse fires once.
- Auto-reload: load 3, auto_reload=1, en=1 for 12 cycles.
  - Required: out sequence 3,2,1,3,2,1,...
  - tc_pulse is high every 3rd cycle, 4 pulses total; busy stays 1.
  - With reload=1: tc_pulse is high on every cycle.
- Load collision: at out==1 with en=1, assert load=1 with load_val=10 -> out=10, tc_pulse=0, state RUN.
  - Also: load_val=0 -> out=0, state IDLE, busy=0, no tc_pulse.
- Width max: N=4, load 15, auto_reload=0, en=1 -> exactly 15 decrements to 0; no wrap to 15; single tc_pulse.
